// File: rtl/cpu_pkg.sv
// Shared definitions for the 18-bit single-cycle CPU execution core.
// Holds the opcode map, ALU function codes and default datapath sizes.
package cpu_pkg;

    localparam int DEF_DW   = 18;
    localparam int DEF_AW   = 10;
    localparam int DEF_IMMW = 6;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_ANDI = 4'b0101,
        OP_ORI  = 4'b0110,
        OP_ADDI = 4'b0111,
        OP_XORI = 4'b1000,
        OP_SUBI = 4'b1001,
        OP_LD   = 4'b1010,
        OP_ST   = 4'b1011,
        OP_JUMP = 4'b1100,
        OP_BEQ  = 4'b1101,
        OP_BNE  = 4'b1110,
        OP_BLT  = 4'b1111
    } opcode_e;

    // The last three codes exist for the ALU only; the decoder never emits them.
    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_XOR   = 3'b011,
        ALU_SUB   = 3'b100,
        ALU_PASSA = 3'b101,
        ALU_PASSB = 3'b110,
        ALU_ZERO  = 3'b111
    } alu_op_e;

    function automatic logic is_alu_opcode(logic [3:0] op);
        return op <= 4'd9;
    endfunction

endpackage

// File: rtl/exec_core_if.sv
// Instruction/operand inputs and control/result outputs of the execution core.
// The master side is the register file / fetch logic, the slave side is exec_core.
interface exec_core_if
    import cpu_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int IMMW = DEF_IMMW
);

    logic [3:0]      opcode;
    logic [DW-1:0]   rs1_data;
    logic [DW-1:0]   rs2_data;
    logic [IMMW-1:0] imm;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   st_data;

    logic [DW-1:0]   write_data;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic [2:0]      alu_op;
    logic            branch;
    logic            pc_write;
    logic            zf;
    logic            cf;

    modport master (
        output opcode, rs1_data, rs2_data, imm, addr, st_data,
        input  write_data, reg_write, mem_read, mem_write, mem_to_reg,
        input  alu_src, alu_op, branch, pc_write, zf, cf
    );

    modport slave (
        input  opcode, rs1_data, rs2_data, imm, addr, st_data,
        output write_data, reg_write, mem_read, mem_write, mem_to_reg,
        output alu_src, alu_op, branch, pc_write, zf, cf
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU with zero, negative and carry/borrow status.
// Carry is the ADD carry-out or the SUB borrow; it is 0 for every other function.
module exec_alu
    import cpu_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_e       op,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          negative,
    output logic          carry_out
);

    logic [DW:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        case (op)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD: begin
                result    = sum[DW-1:0];
                carry_out = sum[DW];
            end
            ALU_XOR:   result = a ^ b;
            ALU_SUB: begin
                result    = a - b;
                carry_out = (a < b);
            end
            ALU_PASSA: result = a;
            ALU_PASSB: result = b;
            ALU_ZERO:  result = '0;
            default:   result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[DW-1];

endmodule

// File: rtl/exec_core.sv
// Execution core: opcode decoder, ZF/CF flag registers, ALU and 1024x18 data memory.
// Produces the write-back value, register/memory enables and the PC redirect request.
module exec_core
    import cpu_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int IMMW = DEF_IMMW
) (
    input  logic     clk,
    input  logic     reset,
    exec_core_if.slave bus
);

    logic [DW-1:0] mem [2**AW];

    logic [DW-1:0] imm_ext;
    logic [DW-1:0] operand_b;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_word;
    logic          alu_zero;
    logic          alu_carry;

    logic          reg_write;
    logic          mem_read;
    logic          dec_mem_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    alu_op_e       alu_op;
    logic          branch;
    logic          pc_write;
    logic          zf;
    logic          cf;

    always_comb begin
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        dec_mem_write = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_AND;
        branch        = 1'b0;
        pc_write      = 1'b0;
        case (opcode_e'(bus.opcode))
            OP_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin reg_write = 1'b1; alu_op = ALU_OR;  end
            OP_ADD:  begin reg_write = 1'b1; alu_op = ALU_ADD; end
            OP_XOR:  begin reg_write = 1'b1; alu_op = ALU_XOR; end
            OP_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
            OP_ANDI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_AND; end
            OP_ORI:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_OR;  end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_ADD; end
            OP_XORI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_XOR; end
            OP_SUBI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALU_SUB; end
            OP_LD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_ST:   dec_mem_write = 1'b1;
            OP_JUMP: pc_write = 1'b1;
            OP_BEQ:  begin branch = 1'b1; pc_write = zf;  end
            OP_BNE:  begin branch = 1'b1; pc_write = ~zf; end
            OP_BLT:  begin branch = 1'b1; pc_write = cf;  end
            default: ;
        endcase
    end

    // Stores are suppressed while the core is held in reset.
    assign mem_write = dec_mem_write & reset;

    assign imm_ext   = {{(DW-IMMW){1'b0}}, bus.imm};
    assign operand_b = alu_src ? imm_ext : bus.rs2_data;

    exec_alu #(.DW(DW)) u_alu (
        .a         (bus.rs1_data),
        .b         (operand_b),
        .op        (alu_op),
        .result    (alu_result),
        .zero      (alu_zero),
        .negative  (),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (is_alu_opcode(bus.opcode)) begin
            zf <= alu_zero;
            cf <= alu_carry;
        end
    end

    // Asynchronous read returns the pre-edge word on a same-address read-during-write.
    assign mem_word = mem[bus.addr];

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[bus.addr] <= bus.st_data;
        end
    end

    assign bus.write_data = mem_to_reg ? mem_word : alu_result;
    assign bus.reg_write  = reg_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.branch     = branch;
    assign bus.pc_write   = pc_write;
    assign bus.zf         = zf;
    assign bus.cf         = cf;

endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core: directed sequences, a constant vector table
// and randomized instructions checked against an arithmetic reference model.
module tb_exec_core;
    import cpu_pkg::*;

    localparam int     DW  = 18;
    localparam int     AW  = 10;
    localparam longint MOD = 64'd1 << DW;

    logic clk;
    logic reset;

    exec_core_if #(.DW(DW), .AW(AW), .IMMW(6)) bus ();

    exec_core #(.DW(DW), .AW(AW), .IMMW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0]    s_op;
    logic [DW-1:0] s_rs1, s_rs2, s_st;
    logic [5:0]    s_imm;
    logic [AW-1:0] s_addr;

    logic [DW-1:0] mm [1024];
    logic          m_zf, m_cf;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [5:0]    imm;
        logic [DW-1:0] exp_wd;
        logic          exp_src;
        logic [2:0]    exp_aluop;
        logic          exp_zf;
        logic          exp_cf;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                                 input logic [5:0] imm, input logic [AW-1:0] addr, input logic [DW-1:0] st);
        s_op = op; s_rs1 = rs1; s_rs2 = rs2; s_imm = imm; s_addr = addr; s_st = st;
        bus.opcode   = op;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
        bus.imm      = imm;
        bus.addr     = addr;
        bus.st_data  = st;
        #1;
    endtask

    // Returns {carry, result} computed from the instruction rules with plain integer arithmetic.
    function automatic logic [DW:0] modelAlu(input logic [3:0] op, input logic [DW-1:0] rs1,
                                             input logic [DW-1:0] rs2, input logic [5:0] imm);
        longint a, b, s;
        int     kind;
        logic [DW-1:0] r;
        logic   c;
        a    = longint'(rs1);
        b    = (op >= 5 && op <= 9) ? longint'(imm) : longint'(rs2);
        kind = (op <= 9) ? int'(op) % 5 : 0;
        c    = 1'b0;
        case (kind)
            0: r = DW'(a & b);
            1: r = DW'(a | b);
            2: begin s = a + b; r = DW'(s % MOD); c = (s >= MOD); end
            3: r = DW'(a ^ b);
            default: begin r = DW'((a - b + MOD) % MOD); c = (a < b); end
        endcase
        return {c, r};
    endfunction

    task automatic checkAll(input string tag);
        logic [DW:0]   r;
        logic [DW-1:0] wd;
        int            op;
        logic          pcw;
        r   = modelAlu(s_op, s_rs1, s_rs2, s_imm);
        op  = int'(s_op);
        wd  = (op == 10) ? mm[s_addr] : r[DW-1:0];
        pcw = (op == 12) || (op == 13 && m_zf) || (op == 14 && !m_zf) || (op == 15 && m_cf);
        checkOutput({tag, ".write_data"}, 32'(bus.write_data), 32'(wd));
        checkOutput({tag, ".reg_write"},  32'(bus.reg_write),  32'(op <= 10));
        checkOutput({tag, ".mem_read"},   32'(bus.mem_read),   32'(op == 10));
        checkOutput({tag, ".mem_write"},  32'(bus.mem_write),  32'(op == 11 && reset));
        checkOutput({tag, ".mem_to_reg"}, 32'(bus.mem_to_reg), 32'(op == 10));
        checkOutput({tag, ".alu_src"},    32'(bus.alu_src),    32'(op >= 5 && op <= 9));
        checkOutput({tag, ".alu_op"},     32'(bus.alu_op),     32'((op <= 9) ? op % 5 : 0));
        checkOutput({tag, ".branch"},     32'(bus.branch),     32'(op >= 13));
        checkOutput({tag, ".pc_write"},   32'(bus.pc_write),   32'(pcw));
        checkOutput({tag, ".zf"},         32'(bus.zf),         32'(m_zf));
        checkOutput({tag, ".cf"},         32'(bus.cf),         32'(m_cf));
    endtask

    // Advances one clock; the model commits the instruction held across the edge.
    task automatic clockEdge();
        logic [DW:0] r;
        r = modelAlu(s_op, s_rs1, s_rs2, s_imm);
        @(posedge clk);
        if (reset) begin
            if (s_op <= 9) begin
                m_zf = (r[DW-1:0] == '0);
                m_cf = r[DW];
            end
            if (s_op == 11) mm[s_addr] = s_st;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        m_zf = 1'b0;
        m_cf = 1'b0;

        vecs[0] = '{4'd0, 18'h3F0F0, 18'h0FF00, 6'h00, 18'h0F000, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{4'd1, 18'h00001, 18'h20000, 6'h00, 18'h20001, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[2] = '{4'd2, 18'h20000, 18'h20000, 6'h00, 18'h00000, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[3] = '{4'd3, 18'h2AAAA, 18'h15555, 6'h00, 18'h3FFFF, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[4] = '{4'd4, 18'h00010, 18'h00001, 6'h00, 18'h0000F, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[5] = '{4'd5, 18'h3FFFF, 18'h12345, 6'h2A, 18'h0002A, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{4'd6, 18'h10000, 18'h12345, 6'h3F, 18'h1003F, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[7] = '{4'd8, 18'h0002A, 18'h12345, 6'h2A, 18'h00000, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[8] = '{4'd9, 18'h00000, 18'h12345, 6'h00, 18'h00000, 1'b1, 3'd4, 1'b1, 1'b0};
        vecs[9] = '{4'd7, 18'h3FFC0, 18'h12345, 6'h3F, 18'h3FFFF, 1'b1, 3'd2, 1'b0, 1'b0};

        // Held in reset: a store must not write, flags read 0.
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(4'd11, 18'h0, 18'h0, 6'h0, 10'h005, 18'h11111);
        checkOutput("rst.mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("rst.zf", 32'(bus.zf), 32'd0);
        checkOutput("rst.cf", 32'(bus.cf), 32'd0);
        clockEdge();
        reset = 1'b1;

        applyStimulus(4'd2, 18'd5, 18'd7, 6'h0, 10'h0, 18'h0);
        checkOutput("add.write_data", 32'(bus.write_data), 32'd12);
        checkOutput("add.reg_write", 32'(bus.reg_write), 32'd1);
        clockEdge();
        checkOutput("add.zf", 32'(bus.zf), 32'd0);
        checkOutput("add.cf", 32'(bus.cf), 32'd0);

        applyStimulus(4'd4, 18'd3, 18'd3, 6'h0, 10'h0, 18'h0);
        checkOutput("sub.write_data", 32'(bus.write_data), 32'd0);
        clockEdge();
        checkOutput("sub.zf", 32'(bus.zf), 32'd1);
        applyStimulus(4'd13, 18'h0, 18'h0, 6'h0, 10'h040, 18'h0);
        checkOutput("beq.branch", 32'(bus.branch), 32'd1);
        checkOutput("beq.pc_write", 32'(bus.pc_write), 32'd1);

        applyStimulus(4'd7, 18'h3FFFF, 18'h0, 6'd1, 10'h0, 18'h0);
        checkOutput("addi.write_data", 32'(bus.write_data), 32'd0);
        clockEdge();
        checkOutput("addi.zf", 32'(bus.zf), 32'd1);
        checkOutput("addi.cf", 32'(bus.cf), 32'd1);
        applyStimulus(4'd14, 18'h0, 18'h0, 6'h0, 10'h040, 18'h0);
        checkOutput("bne.pc_write", 32'(bus.pc_write), 32'd0);

        applyStimulus(4'd9, 18'd2, 18'h0, 6'd5, 10'h0, 18'h0);
        checkOutput("subi.write_data", 32'(bus.write_data), 32'h3FFFD);
        clockEdge();
        checkOutput("subi.cf", 32'(bus.cf), 32'd1);
        applyStimulus(4'd15, 18'h0, 18'h0, 6'h0, 10'h040, 18'h0);
        checkOutput("blt.pc_write", 32'(bus.pc_write), 32'd1);

        applyStimulus(4'd11, 18'h0, 18'h0, 6'h0, 10'h3FF, 18'h2AAAA);
        checkOutput("st.mem_write", 32'(bus.mem_write), 32'd1);
        checkOutput("st.reg_write", 32'(bus.reg_write), 32'd0);
        clockEdge();
        applyStimulus(4'd10, 18'h0, 18'h0, 6'h0, 10'h3FF, 18'h0);
        checkOutput("ld.write_data", 32'(bus.write_data), 32'h2AAAA);
        checkOutput("ld.mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        applyStimulus(4'd10, 18'h0, 18'h0, 6'h0, 10'h001, 18'h0);
        checkOutput("ld_fresh.write_data", 32'(bus.write_data), 32'd0);
        applyStimulus(4'd10, 18'h0, 18'h0, 6'h0, 10'h005, 18'h0);
        checkOutput("ld_rststore.write_data", 32'(bus.write_data), 32'd0);

        // Mid-cycle reset clears the flags without any clock edge.
        applyStimulus(4'd4, 18'd9, 18'd9, 6'h0, 10'h0, 18'h0);
        clockEdge();
        checkOutput("pre_rst.zf", 32'(bus.zf), 32'd1);
        applyStimulus(4'd12, 18'h0, 18'h0, 6'h0, 10'h123, 18'h0);
        #2;
        reset = 1'b0;
        #1;
        m_zf = 1'b0;
        m_cf = 1'b0;
        checkOutput("async_rst.zf", 32'(bus.zf), 32'd0);
        checkOutput("async_rst.cf", 32'(bus.cf), 32'd0);
        checkOutput("jump.pc_write", 32'(bus.pc_write), 32'd1);
        clockEdge();
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 10'h0, 18'h0);
            checkOutput($sformatf("vec%0d.write_data", i), 32'(bus.write_data), 32'(vecs[i].exp_wd));
            checkOutput($sformatf("vec%0d.alu_src", i), 32'(bus.alu_src), 32'(vecs[i].exp_src));
            checkOutput($sformatf("vec%0d.alu_op", i), 32'(bus.alu_op), 32'(vecs[i].exp_aluop));
            clockEdge();
            checkOutput($sformatf("vec%0d.zf", i), 32'(bus.zf), 32'(vecs[i].exp_zf));
            checkOutput($sformatf("vec%0d.cf", i), 32'(bus.cf), 32'(vecs[i].exp_cf));
            applyStimulus(4'd12, 18'h0, 18'h0, 6'h0, 10'h0, 18'h0);
            checkOutput($sformatf("vec%0d.jump", i), 32'(bus.pc_write), 32'd1);
        end

        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            applyStimulus(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
                          6'($urandom), a, DW'($urandom));
            checkAll($sformatf("rnd%0d", i));
            clockEdge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_core.md
Name: exec_core

Overview:
- Execution core of the 18-bit single-cycle CPU.
- Bundles three functions in one block:
  - Instruction decoder/control unit, which also holds the ZF/CF flags.
  - 18-bit ALU.
  - 1024x18 data memory.
- Sits between the register file / instruction memory and the PC logic.
- Produces the register write-back data, register/memory enables and the PC redirect request.

Parameters:
- DW, 18, datapath width.
- AW, 10, data memory address width (depth 2**AW).
- IMMW, 6, immediate width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  4  instruction bits [17:14].
- rs1_data  in  DW  register-file read port 1 (ALU operand A).
- rs2_data  in  DW  register-file read port 2 (ALU operand B, R-type).
- imm  in  IMMW  instruction bits [5:0].
- addr  in  AW  instruction bits [9:0] (memory address / jump-branch target).
- st_data  in  DW  value to store (register selected by rd).
- write_data  out  DW  register write-back value.
- reg_write  out  1  register-file write enable.
- mem_read  out  1  data memory read strobe.
- mem_write  out  1  data memory write enable.
- mem_to_reg  out  1  write_data select: memory vs ALU.
- alu_src  out  1  ALU operand B select: immediate vs rs2_data.
- alu_op  out  3  ALU function select.
- branch  out  1  current opcode is a conditional branch.
- pc_write  out  1  load PC with addr this cycle.
- zf  out  1  registered zero flag.
- cf  out  1  registered carry/borrow flag.

Behaviour:
- Decode is fully combinational from opcode.
- Opcode map (alu_op in brackets):
  - R-type: 0000 AND[000], 0001 OR[001], 0010 ADD[010], 0011 XOR[011], 0100 SUB[100]; reg_write=1, alu_src=0.
  - I-type: 0101 ANDI[000], 0110 ORI[001], 0111 ADDI[010], 1000 XORI[011], 1001 SUBI[100]; reg_write=1, alu_src=1.
  - 1010 LD: mem_read=1, mem_to_reg=1, reg_write=1.
  - 1011 ST: mem_write=1.
  - 1100 JUMP: pc_write=1.
  - 1101 BEQ, 1110 BNE, 1111 BLT: branch=1; pc_write = zf, ~zf, cf respectively.
  - All unlisted control outputs are 0; alu_op is 000 for non-ALU opcodes.
- Immediate is zero-extended to DW.
- ALU is combinational. Operand B = alu_src ? {0, imm} : rs2_data.
  - Functions: 000 A&B, 001 A|B, 010 A+B, 011 A^B, 100 A-B.
  - 101 pass A, 110 pass B, 111 zero; these three codes are not generated by the decoder.
  - zero = (result == 0).
  - negative = result[DW-1].
  - carry_out = bit DW of A+B for ADD; = (A < B unsigned) for SUB (borrow); 0 for all other functions.
- Flags:
  - On a rising clk edge with an ALU opcode (0000-1001): zf <= zero, cf <= carry_out.
  - Otherwise flags hold.
  - reset low forces zf=0 and cf=0 immediately.
- Data memory: 2**AW words.
  - Write on rising clk when mem_write=1: mem[addr] <= st_data.
  - Read is combinational: mem[addr].
  - Read-during-write to the same address returns the old word in that cycle.
  - Contents are not affected by reset; all words are zero at power-up.
  - Address wraps naturally (AW bits).
- write_data = mem_to_reg ? mem[addr] : alu_result.
- Arithmetic wraps modulo 2**DW.
- While reset is low: mem_write is forced to 0, and the flags are held at 0. Decode outputs otherwise follow opcode.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants (OP_AND..OP_BLT).
  - ALU op constants (ALU_AND..ALU_ZERO).
  - DW/AW/IMMW defaults.
- One natural sub-module: exec_alu (combinational ALU with zero/negative/carry_out).
- Decoder, flag registers and memory stay in exec_core.

Test Plan:
- Reset low, then ADD with rs1=5, rs2=7 -> write_data=12, reg_write=1. Next edge: zf=0, cf=0.
- SUB with rs1=3, rs2=3 -> write_data=0. After edge zf=1. BEQ addr=0x040 -> branch=1, pc_write=1.
- ADDI rs1=0x3FFFF, imm=1 -> write_data=0. After edge zf=1, cf=1. BNE -> pc_write=0.
- SUBI rs1=2, imm=5 -> write_data=0x3FFFD, cf=1 after edge. BLT -> pc_write=1.
- ST addr=0x3FF, st_data=0x2AAAA; next cycle LD addr=0x3FF -> write_data=0x2AAAA, mem_to_reg=1. Fresh address 0x001 reads 0.
- Set zf=1, then assert reset low mid-cycle -> zf=cf=0 without a clock edge. JUMP -> pc_write=1 regardless of flags.
